seq_cmp: RTL
============

SEQ_CMP -- requirements
Module: seq_cmp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits compared per cycle.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a new comparison.
REQ-007 The block SHALL have port op, input, 3 bits: operation select.
REQ-008 The block SHALL have port X, input, WIDTH bits: first operand.
REQ-009 The block SHALL have port Y, input, WIDTH bits: second operand.
REQ-010 The block SHALL have port busy, output, 1 bit: a comparison is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion strobe.
REQ-012 The block SHALL have port result, output, WIDTH bits: comparison outcome, zero-extended 0 or 1.

Function
REQ-013 WIDTH SHALL be a multiple of CHUNK, and CHUNK SHALL be at least 1; any violation SHALL fail elaboration. NCHUNK = WIDTH/CHUNK.
REQ-014 The op encoding SHALL be:
- 000 SLT (signed X<Y)
- 001 SLTU (unsigned X<Y)
- 010 EQ
- 011 NE
- 100 SGE (signed X>=Y)
- 101 SGEU (unsigned X>=Y)
- 110 and 111 reserved: result 0, with normal timing.
REQ-015 The state machine SHALL have three states: IDLE, SCAN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL, on the clock edge:
- latch X, Y and op;
- set the chunk index to NCHUNK-1;
- move to SCAN.
REQ-017 start SHALL be ignored while in SCAN; the latched operands SHALL be unaffected by changes on X, Y or op after acceptance.
REQ-018 Each SCAN cycle SHALL compare the current chunk of the latched X and Y, scanning MSB-first.
- For signed ops (SLT, SGE), the top bit of chunk NCHUNK-1 SHALL be inverted in both operands before the unsigned chunk compare.
REQ-019 In SCAN, when the chunks differ, the block SHALL decide lt = (Xchunk < Ychunk) and eq = 0, then move to DONE.
- When the chunks are equal and the index is 0, it SHALL decide lt = 0 and eq = 1, then move to DONE.
- Otherwise it SHALL decrement the index and remain in SCAN (early termination on the first differing chunk).
REQ-020 On the deciding edge, result SHALL be loaded with the op function of lt and eq:
- SLT/SLTU = lt
- EQ = eq
- NE = !eq
- SGE/SGEU = !lt
- reserved = 0
REQ-021 busy SHALL be 1 exactly while the state is SCAN; done SHALL be 1 exactly while the state is DONE.
- DONE SHALL last one cycle and then return to IDLE, unless start=1, which moves it to SCAN per REQ-016.
REQ-022 Latency SHALL follow from the m chunks examined (1 <= m <= NCHUNK):
- start sampled at edge E;
- done SHALL be high in the cycle after edge E+m;
- no other done pulse SHALL occur.
REQ-023 result SHALL hold its value between decisions; it SHALL NOT change in IDLE, SCAN or DONE except on a deciding edge.
REQ-024 With CHUNK = WIDTH, every comparison SHALL take m = 1.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set:
- state IDLE
- busy 0
- done 0
- result 0
- chunk index NCHUNK-1
REQ-026 rst SHALL take priority over start.
REQ-027 rst during SCAN or DONE SHALL abort the comparison with no done pulse and a result of 0.

Verification (WIDTH=32, CHUNK=8)
REQ-028 A bench SHALL apply SLT with X=1, Y=2 and check:
- busy high for 4 cycles;
- done 4 cycles after the start edge;
- result=1.
REQ-029 A bench SHALL apply SLT with X=0xFFFFFFFF, Y=1 and check m=1 and result=1.
- The same operands with SLTU SHALL give m=1 and result=0.
REQ-030 A bench SHALL apply EQ with X=Y=2 and check m=4 and result=1; NE with the same operands SHALL give result=0.
REQ-031 A bench SHALL apply SGE with X=1, Y=0xFFFFFFFF and check m=1 and result=1.
- It SHALL then assert start in the DONE cycle with SLTU, X=3, Y=2, and check:
  - busy is 1 on the next cycle;
  - the second done comes 4 cycles later;
  - result=0.
REQ-032 A bench SHALL start SLTU with X=0x00000100, Y=0x00000200, assert rst on the 2nd SCAN cycle, and check:
- no done pulse;
- result=0;
- busy=0 after that edge.
REQ-033 A bench SHALL check that start pulses in SCAN are ignored:
- the result matches the first request;
- exactly one done pulse occurs.

Source files
------------

// File: rtl/seq_cmp.sv
// seq_cmp: multi-cycle comparator that scans operands MSB-first in CHUNK-bit slices.
// Ports: clk, rst (sync, active high), start/op/X/Y request; busy, done, result status.
module seq_cmp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    localparam logic [2:0] OP_SLT  = 3'b000;
    localparam logic [2:0] OP_SLTU = 3'b001;
    localparam logic [2:0] OP_EQ   = 3'b010;
    localparam logic [2:0] OP_NE   = 3'b011;
    localparam logic [2:0] OP_SGE  = 3'b100;
    localparam logic [2:0] OP_SGEU = 3'b101;

    localparam bit BAD_CFG = (CHUNK < 1) ? 1'b1 : ((WIDTH % CHUNK) != 0);

    generate
        if (BAD_CFG) begin : g_bad_cfg
            $error("seq_cmp: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [2:0]        op_q, op_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  res_q, res_d;

    logic [CHUNK-1:0]  xc, yc;
    logic              sgn;
    logic              differ;
    logic              lt, eq;
    logic              fbit;

    // Current slices; for signed ops the sign bit is flipped so that an
    // unsigned compare of the top slice orders two's-complement values.
    always_comb begin
        xc  = x_q[int'(idx_q) * CHUNK +: CHUNK];
        yc  = y_q[int'(idx_q) * CHUNK +: CHUNK];
        sgn = (op_q == OP_SLT) || (op_q == OP_SGE);
        if (sgn && (idx_q == TOP)) begin
            xc[CHUNK-1] = ~xc[CHUNK-1];
            yc[CHUNK-1] = ~yc[CHUNK-1];
        end
        differ = (xc != yc);
        lt     = differ && (xc < yc);
        eq     = !differ;
    end

    always_comb begin
        fbit = 1'b0;
        case (op_q)
            OP_SLT, OP_SLTU: fbit = lt;
            OP_EQ:           fbit = eq;
            OP_NE:           fbit = !eq;
            OP_SGE, OP_SGEU: fbit = !lt;
            default:         fbit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        idx_d   = idx_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    x_d     = X;
                    y_d     = Y;
                    op_d    = op;
                    idx_d   = TOP;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                // Stop on the first differing slice or after the last one.
                if (differ || (idx_q == '0)) begin
                    res_d   = WIDTH'(fbit);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            idx_q   <= TOP;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q == S_SCAN);
    assign done   = (state_q == S_DONE);
    assign result = res_q;

endmodule
